adc_sample_capture: RTL and testbench
=====================================

Name: adc_sample_capture

Overview:
Receive-side companion to the decade ADC clock divider. It watches ADC_CLK and latches parallel ADC data once per ADC_CLK period, on the falling edge. A start command captures a programmed number of samples, which are buffered in a first-word-fall-through FIFO. Downstream logic drains the FIFO over a valid/ready read port.

Parameters:
DATA_W, 8, ADC sample width in bits
DEPTH, 16, FIFO depth in words; power of 2, minimum 4
CNT_W, 16, width of the sample-count request

Ports:
clk  input  1  system clock; same clock that drives the divider
rst_n  input  1  asynchronous active-low reset
ADC_CLK  input  1  ADC clock from the divider; registered in the clk domain, no synchroniser
adc_data  input  DATA_W  ADC parallel output; stable around the ADC_CLK falling edge
start  input  1  single-cycle capture request
sample_num  input  CNT_W  number of samples to capture; sampled when start is accepted
rd_data  output  DATA_W  FIFO head word
rd_valid  output  1  FIFO not empty
rd_ready  input  1  consumer accepts rd_data
busy  output  1  capture in progress (ARM or CAPTURE)
done  output  1  one-cycle pulse when capture completes
overflow  output  1  sticky: at least one sample was dropped because the FIFO was full
level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, sample counter 0, ADC_CLK history register 0.
- Edge detection uses a register clk_d = ADC_CLK delayed by one clk.
  - rise = !clk_d && ADC_CLK.
  - strobe = clk_d && !ADC_CLK (falling edge).
  - adc_data is taken in the same cycle that strobe is high.
- State machine:
  - IDLE: start && sample_num != 0 → ARM. On this transition, latch sample_num, clear the counter and clear overflow. start with sample_num == 0 is ignored.
  - ARM: rise → CAPTURE. Strobes in ARM are ignored; this aligns capture to a whole ADC_CLK period.
  - CAPTURE: on each strobe, write to the FIFO and increment the counter. When a strobe occurs with counter == latched_num-1 → IDLE, and done pulses high in the next clk cycle.
- busy = (state != IDLE). start while busy is ignored; the latched count is unchanged.
- Dropped samples: a strobe when the FIFO is full and there is no pop in the same cycle drops the sample. The drop sets overflow, and the sample still counts toward sample_num.
- FIFO behaviour:
  - FWFT: rd_valid = !empty; rd_data always shows the head word.
  - Pop when rd_valid && rd_ready.
  - Push and pop in the same cycle: level is unchanged. This is allowed when full (the slot is freed) and when empty cannot occur (push lands next cycle).
- Latency: a sample written on strobe cycle T is visible on rd_data/rd_valid at T+1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is a separate counter, incremented on push and decremented on pop.
- FIFO contents persist across captures; only reset clears them. overflow clears on the next accepted start.
- Asynchronous reset mid-capture: FSM returns to IDLE, FIFO is flushed, no done pulse is generated.
- Counter width: compare is done on CNT_W bits; sample_num = 2^CNT_W-1 is supported.

Decomposition:
- Package adc_cap_pkg holds:
  - the state enum: IDLE, ARM, CAPTURE;
  - a localparam function for the level width ($clog2(DEPTH)+1).
- One sub-module, sync_fifo_fwft, parameterised by DATA_W and DEPTH. It exposes push, wdata, pop, rdata, empty, full and level.
- The top level contains the edge detector, the FSM, the counter and the overflow flag.

Test Plan:
- Stimulus conditions for all scenarios: ADC_CLK from the divider with div=1 (toggles every 10 clk); adc_data increments by 1 at each ADC_CLK rising edge, starting at 0x10.
- Basic capture: sample_num=4, rd_ready=1 → exactly 4 words read, consecutive values. done pulses once, one cycle after the 4th strobe. busy falls the same cycle done rises. overflow=0.
- Overflow: DEPTH=16, sample_num=20, rd_ready=0 → level saturates at 16 and overflow=1. done still pulses after the 20th strobe. Draining yields the first 16 samples in order.
- Ignored starts:
  - start with sample_num=0 → busy stays 0;
  - start asserted while in CAPTURE with sample_num=8 → the original count completes with no restart.
- Full with simultaneous pop: FIFO full and rd_ready pulsed in a strobe cycle → level stays 16, no overflow, the new sample lands at the tail.
- Reset mid-capture: assert rst_n=0 after 3 of 10 samples → all outputs 0 immediately, level=0, no done pulse. After release, a new capture with sample_num=2 works normally.
- Alignment: start issued while ADC_CLK is high → the first captured sample comes from the falling edge after the next rising edge, not the immediate falling edge.

Source files
------------

// File: rtl/adc_sample_capture_pkg.sv
// Shared types for the ADC sample capture path.
// Capture FSM states and FIFO sizing helper.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy count.
// Push into a full FIFO is accepted only when a pop frees the slot.
module sync_fifo_fwft
  import adc_cap_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int LW     = lvl_w(DEPTH),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head word masked so an empty FIFO presents zero.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        level <= level + LW'(1);
      else if (do_pop && !do_push)
        level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/adc_sample_capture.sv
// Captures a programmed number of ADC samples on ADC_CLK
// falling edges into a FWFT FIFO drained over valid/ready.
module adc_sample_capture
  import adc_cap_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  parameter int  CNT_W  = 16,
  localparam int LW     = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ADC_CLK,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              start,
  input  logic [CNT_W-1:0]  sample_num,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [LW-1:0]     level
);

  cap_state_t       state;
  cap_state_t       nxt;
  logic             clk_d;
  logic             rise;
  logic             strobe;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             cap;
  logic             last;
  logic             pop;
  logic             empty;
  logic             full;
  logic             drop;

  assign rise     = !clk_d && ADC_CLK;
  assign strobe   = clk_d && !ADC_CLK;
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign accept   = start && (sample_num != '0);
  assign last     = (cnt_q == num_q - CNT_W'(1));
  assign drop     = cap && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      clk_d <= 1'b0;
    end else begin
      state <= nxt;
      clk_d <= ADC_CLK;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept)         nxt = ARM;
      ARM:     if (rise)           nxt = CAPTURE;
      CAPTURE: if (strobe && last) nxt = IDLE;
      default:                     nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    cap  = (state == CAPTURE) && strobe;
  end

  // Dropped samples still advance the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q    <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= cap && last;
      if (state == IDLE && accept) begin
        num_q    <= sample_num;
        cnt_q    <= '0;
        overflow <= 1'b0;
      end else begin
        if (cap)  cnt_q    <= cnt_q + CNT_W'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap),
    .wdata (adc_data),
    .pop   (pop),
    .rdata (rd_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_adc_sample_capture.sv
// Bench for adc_sample_capture: queue-based reference model,
// capture table, corner-case sequences and random traffic.
module tb_adc_sample_capture;
  import adc_cap_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int LW     = lvl_w(DEPTH);

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              ADC_CLK    = 1'b0;
  logic [DATA_W-1:0] adc_data   = 8'h10;
  logic              start      = 1'b0;
  logic [CNT_W-1:0]  sample_num = '0;
  logic              rd_ready   = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [LW-1:0]     level;

  always #5 clk = ~clk;

  adc_sample_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ADC_CLK    (ADC_CLK),
    .adc_data   (adc_data),
    .start      (start),
    .sample_num (sample_num),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .level      (level)
  );

  int n_chk    = 0;
  int n_pass   = 0;
  int gen_ph   = 0;
  bit gen_fell = 0;
  int dut_done = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_cap[$];
  logic [DATA_W-1:0] got[$];
  int m_mode = 0;
  int m_rem  = 0;
  bit m_ovf  = 0;
  bit m_done = 0;
  bit m_prev = 0;

  typedef struct {
    int num;
    bit rdy;
    int words;
    bit ovf;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h",
                  nm, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_rem  = 0;
    m_ovf  = 0;
    m_done = 0;
    m_prev = 0;
  endtask

  task automatic tick();
    bit fall, rs, pop;
    int old;
    logic [16:0] a, e;
    fall = m_prev && !ADC_CLK;
    rs   = !m_prev && ADC_CLK;
    pop  = rd_ready && (mq.size() > 0);
    old  = m_mode;
    if (rd_valid && rd_ready) got.push_back(rd_data);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = 0;
      if (pop) void'(mq.pop_front());
      if (old == 2 && fall) begin
        m_cap.push_back(adc_data);
        if (mq.size() < DEPTH) mq.push_back(adc_data);
        else m_ovf = 1;
        m_rem--;
        if (m_rem == 0) begin
          m_mode = 0;
          m_done = 1;
        end
      end
      if (old == 1 && rs) m_mode = 2;
      if (old == 0 && start && sample_num != 0) begin
        m_mode = 1;
        m_rem  = int'(sample_num);
        m_ovf  = 0;
      end
      m_prev = ADC_CLK;
    end
    #1;
    if (done) dut_done++;
    a = {busy, done, overflow, rd_valid, level,
         rd_valid ? rd_data : 8'h00};
    e = {m_mode != 0, m_done, m_ovf, mq.size() > 0,
         LW'(mq.size()),
         mq.size() > 0 ? mq[0] : 8'h00};
    chk("cycle", 32'(a), 32'(e));
    gen_fell = 0;
    gen_ph++;
    if (gen_ph == 10) begin
      gen_ph  = 0;
      ADC_CLK = ~ADC_CLK;
      if (ADC_CLK) adc_data = adc_data + 8'd1;
      else gen_fell = 1;
    end
  endtask

  task automatic do_start(input int n);
    got.delete();
    m_cap.delete();
    start      = 1'b1;
    sample_num = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_level(input int n, input int budget);
    int k = 0;
    while (level != LW'(n) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_level", 32'(level), n);
  endtask

  task automatic drain();
    int k = 0;
    rd_ready = 1'b1;
    while (rd_valid && k < DEPTH + 4) begin
      tick();
      k++;
    end
    tick();
    rd_ready = 1'b0;
    chk("drain", 32'(rd_valid), 0);
  endtask

  function automatic int data_err();
    int bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (i >= m_cap.size() || got[i] !== m_cap[i])
        bad++;
    return bad;
  endfunction

  initial begin
    vec_t tbl[6];
    int d0, k;
    logic [DATA_W-1:0] e8;

    tbl[0] = '{4,  1'b1, 4,  1'b0};
    tbl[1] = '{20, 1'b0, 16, 1'b1};
    tbl[2] = '{1,  1'b1, 1,  1'b0};
    tbl[3] = '{16, 1'b0, 16, 1'b0};
    tbl[4] = '{17, 1'b0, 16, 1'b1};
    tbl[5] = '{3,  1'b0, 3,  1'b0};

    repeat (3) tick();
    chk("reset_out",
        32'({busy, done, overflow, rd_valid, level, rd_data}),
        0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      rd_ready = tbl[i].rdy;
      d0 = dut_done;
      do_start(tbl[i].num);
      wait_idle(tbl[i].num * 20 + 80);
      chk("tbl_done", dut_done - d0, 1);
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
      drain();
      chk("tbl_words", got.size(), tbl[i].words);
      chk("tbl_data", data_err(), 0);
    end

    start      = 1'b1;
    sample_num = '0;
    tick();
    start = 1'b0;
    tick();
    chk("zero_start", 32'(busy), 0);

    rd_ready = 1'b1;
    d0 = dut_done;
    do_start(5);
    repeat (45) tick();
    chk("in_capture", 32'(busy), 1);
    start      = 1'b1;
    sample_num = CNT_W'(8);
    tick();
    start = 1'b0;
    wait_idle(200);
    chk("busy_start_done", dut_done - d0, 1);
    drain();
    chk("busy_start_words", got.size(), 5);
    chk("busy_start_data", data_err(), 0);
    repeat (40) tick();
    chk("no_restart", 32'(busy), 0);

    rd_ready = 1'b0;
    d0 = dut_done;
    do_start(17);
    wait_level(16, 17 * 20 + 80);
    k = 0;
    while (!gen_fell && k < 40) begin
      tick();
      k++;
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("full_pop_level", 32'(level), 16);
    chk("full_pop_ovf", 32'(overflow), 0);
    wait_idle(80);
    drain();
    chk("full_pop_done", dut_done - d0, 1);
    chk("full_pop_words", got.size(), 17);
    chk("full_pop_data", data_err(), 0);

    rd_ready = 1'b0;
    do_start(10);
    wait_level(3, 200);
    d0 = dut_done;
    rst_n = 1'b0;
    #1;
    chk("rst_async",
        32'({busy, done, overflow, rd_valid, level, rd_data}),
        0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    chk("rst_no_done", dut_done - d0, 0);
    chk("rst_idle", 32'({busy, level}), 0);
    rd_ready = 1'b1;
    d0 = dut_done;
    do_start(2);
    wait_idle(150);
    drain();
    chk("post_rst_done", dut_done - d0, 1);
    chk("post_rst_words", got.size(), 2);
    chk("post_rst_data", data_err(), 0);

    rd_ready = 1'b1;
    k = 0;
    while (!(ADC_CLK && gen_ph == 5) && k < 40) begin
      tick();
      k++;
    end
    e8 = adc_data + 8'd1;
    do_start(1);
    wait_idle(120);
    drain();
    chk("align_words", got.size(), 1);
    chk("align_word",
        32'(got.size() > 0 ? got[0] : 8'h00), 32'(e8));

    for (int it = 0; it < 8; it++) begin
      rd_ready = 1'($urandom_range(0, 1));
      do_start($urandom_range(1, 24));
      k = 0;
      while (busy && k < 700) begin
        rd_ready   = 1'($urandom_range(0, 1));
        start      = (m_mode == 2) && (m_rem > 2) &&
                     ($urandom_range(0, 7) == 0);
        sample_num = CNT_W'($urandom_range(0, 30));
        tick();
        k++;
      end
      start = 1'b0;
      chk("rand_idle", 32'(busy), 0);
      drain();
      repeat ($urandom_range(0, 15)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
